// File: rtl/tug_if.sv
// Playfield bus: raw player keys in, light field, press pulses and game result out.
interface tug_if #(
    parameter int unsigned NUM_LIGHTS = 9
);
    logic                  key_l_raw;
    logic                  key_r_raw;
    logic [NUM_LIGHTS-1:0] leds;
    logic                  l_pulse;
    logic                  r_pulse;
    logic                  win_pulse;
    logic [1:0]            winner;

    modport master (
        output key_l_raw, key_r_raw,
        input  leds, l_pulse, r_pulse, win_pulse, winner
    );

    modport slave (
        input  key_l_raw, key_r_raw,
        output leds, l_pulse, r_pulse, win_pulse, winner
    );
endinterface

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: key synchronise/edge-detect, one-hot light mover, game-over freeze.
module tug_playfield #(
    parameter int unsigned NUM_LIGHTS = 9,
    parameter int unsigned CENTER     = 5
) (
    input logic clk,
    input logic reset,
    tug_if.slave bus
);
    localparam int unsigned POS_W = $clog2(NUM_LIGHTS + 1);

    typedef enum logic {
        PLAY = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [POS_W-1:0] pos, pos_d;
    logic [1:0]       winner_q, winner_d;
    logic             win_pulse_q, win_pulse_d;

    // bit 0 = s1, bit 1 = s2, bit 2 = s3; all ones at reset so a held key is not a press
    logic [2:0] sync_l, sync_r;
    logic       l_press, r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_l <= 3'b111;
            sync_r <= 3'b111;
        end else begin
            sync_l <= {sync_l[1:0], bus.key_l_raw};
            sync_r <= {sync_r[1:0], bus.key_r_raw};
        end
    end

    assign l_press = sync_l[1] & ~sync_l[2];
    assign r_press = sync_r[1] & ~sync_r[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLAY;
            pos         <= POS_W'(CENTER);
            winner_q    <= 2'b00;
            win_pulse_q <= 1'b0;
        end else begin
            state       <= state_d;
            pos         <= pos_d;
            winner_q    <= winner_d;
            win_pulse_q <= win_pulse_d;
        end
    end

    // Simultaneous presses cancel; pushing past either end finishes the game.
    always_comb begin
        state_d     = state;
        pos_d       = pos;
        winner_d    = winner_q;
        win_pulse_d = 1'b0;
        case (state)
            PLAY: begin
                if (l_press && !r_press) begin
                    if (pos == POS_W'(NUM_LIGHTS)) begin
                        state_d     = DONE;
                        winner_d    = 2'b10;
                        win_pulse_d = 1'b1;
                    end else begin
                        pos_d = pos + POS_W'(1);
                    end
                end else if (r_press && !l_press) begin
                    if (pos == POS_W'(1)) begin
                        state_d     = DONE;
                        winner_d    = 2'b01;
                        win_pulse_d = 1'b1;
                    end else begin
                        pos_d = pos - POS_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // Field is decoded from registered state, so it still shows the pre-move light during a pulse.
    logic [NUM_LIGHTS-1:0] leds_c;
    always_comb begin
        leds_c = '0;
        if (state == PLAY) begin
            leds_c = NUM_LIGHTS'(1) << (pos - POS_W'(1));
        end
    end

    assign bus.leds      = leds_c;
    assign bus.l_pulse   = l_press;
    assign bus.r_pulse   = r_press;
    assign bus.win_pulse = win_pulse_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_tug_playfield.sv
// Randomised + directed bench for tug_playfield with a game-level reference model and scoreboard.
module tb_tug_playfield;
    localparam int unsigned NL  = 9;
    localparam int unsigned CTR = 5;

    logic clk;
    logic reset;

    tug_if #(.NUM_LIGHTS(NL)) bus ();

    tug_playfield #(.NUM_LIGHTS(NL), .CENTER(CTR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NL-1:0] leds;
        logic          l;
        logic          r;
        logic          w;
        logic [1:0]    winner;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a key press is recognised two cycles after the sampled level rises
    // (reset counts as "key already held"); the game is a bounded walk on 1..NL.
    initial begin : model
        bit    hl[3];
        bit    hr[3];
        int    pos;
        bit    over;
        logic [1:0] win;
        logic [NL-1:0] one;
        bit    lp, rp, wp;
        obs_t  e;
        one  = NL'(1);
        pos  = CTR;
        over = 1'b0;
        win  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            hl[i] = 1'b1;
            hr[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            lp = hl[1] & ~hl[2];
            rp = hr[1] & ~hr[2];
            wp = 1'b0;
            if (reset) begin
                pos  = CTR;
                over = 1'b0;
                win  = 2'b00;
                for (int i = 0; i < 3; i++) begin
                    hl[i] = 1'b1;
                    hr[i] = 1'b1;
                end
            end else begin
                if (!over && (lp != rp)) begin
                    if (lp) begin
                        if (pos == NL) begin over = 1'b1; win = 2'b10; wp = 1'b1; end
                        else pos = pos + 1;
                    end else begin
                        if (pos == 1) begin over = 1'b1; win = 2'b01; wp = 1'b1; end
                        else pos = pos - 1;
                    end
                end
                hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = bus.key_l_raw;
                hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = bus.key_r_raw;
            end
            e.leds   = over ? '0 : (one << (pos - 1));
            e.l      = hl[1] & ~hl[2];
            e.r      = hr[1] & ~hr[2];
            e.w      = wp;
            e.winner = win;
            exp_q.push_back(e);
        end
    end

    // Monitor: one observation per cycle, compared away from the active edge.
    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{leds: bus.leds, l: bus.l_pulse, r: bus.r_pulse,
                      w: bus.win_pulse, winner: bus.winner};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_obs: got leds=%b l=%b r=%b w=%b win=%b expected leds=%b l=%b r=%b w=%b win=%b at %0t",
                             a.leds, a.l, a.r, a.w, a.winner, e.leds, e.l, e.r, e.w, e.winner, $time);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit l, input bit r, input int hold, input int gap);
        bus.key_l_raw = l;
        bus.key_r_raw = r;
        step(hold);
        bus.key_l_raw = 1'b0;
        bus.key_r_raw = 1'b0;
        step(gap);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    initial begin : driver
        bit seen;
        int fav, act;
        reset         = 1'b1;
        bus.key_l_raw = 1'b0;
        bus.key_r_raw = 1'b0;
        step(3);
        reset = 1'b0;

        // idle after reset
        step(5);
        chk("reset_leds", 16'(bus.leds), 16'h010);
        chk("reset_pulses", 16'({bus.l_pulse, bus.r_pulse, bus.win_pulse}), 16'h0);
        chk("reset_winner", 16'(bus.winner), 16'h0);

        // single-cycle left press: pulse two cycles later, then one step left
        bus.key_l_raw = 1'b1;
        step(1);
        bus.key_l_raw = 1'b0;
        step(1);
        chk("l_pulse_hi", 16'(bus.l_pulse), 16'h1);
        chk("l_pulse_leds_premove", 16'(bus.leds), 16'h010);
        step(1);
        chk("l_pulse_lo", 16'(bus.l_pulse), 16'h0);
        chk("l_move_leds", 16'(bus.leds), 16'h020);

        // held right key: exactly one step
        press(1'b0, 1'b1, 20, 4);
        chk("hold_r_leds", 16'(bus.leds), 16'h010);

        // both keys together cancel
        bus.key_l_raw = 1'b1;
        bus.key_r_raw = 1'b1;
        step(2);
        chk("both_pulses", 16'({bus.l_pulse, bus.r_pulse}), 16'h3);
        press(1'b0, 1'b0, 1, 3);
        chk("both_leds", 16'(bus.leds), 16'h010);

        // right player wins from centre
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 2, 3);
        chk("r_end_leds", 16'(bus.leds), 16'h001);
        bus.key_r_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(1);
            if (bus.r_pulse === 1'b1) seen = 1'b1;
        end
        chk("r_win_pulse_seen", 16'(seen), 16'h1);
        chk("r_win_leds0_with_pulse", 16'(bus.leds[0]), 16'h1);
        step(1);
        bus.key_r_raw = 1'b0;
        chk("r_win_pulse", 16'(bus.win_pulse), 16'h1);
        chk("r_win_winner", 16'(bus.winner), 16'h1);
        chk("r_win_leds", 16'(bus.leds), 16'h0);
        step(1);
        chk("r_win_pulse_once", 16'(bus.win_pulse), 16'h0);
        press(1'b1, 1'b0, 2, 3);
        press(1'b0, 1'b1, 2, 3);
        chk("done_winner_held", 16'(bus.winner), 16'h1);
        chk("done_leds_blank", 16'(bus.leds), 16'h0);

        // reset mid-press with left key held through reset
        do_reset(2);
        step(2);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 2, 3);
        chk("l_top_leds", 16'(bus.leds), 16'h100);
        bus.key_l_raw = 1'b1;
        step(1);
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("held_through_reset_no_pulse", 16'(bus.l_pulse), 16'h0);
        end
        chk("held_through_reset_leds", 16'(bus.leds), 16'h010);
        bus.key_l_raw = 1'b0;
        step(3);
        press(1'b1, 1'b0, 2, 3);
        chk("repress_leds", 16'(bus.leds), 16'h020);

        // randomised games, each biased towards one side so some reach an end
        for (int g = 0; g < 40; g++) begin
            fav = int'($urandom_range(0, 1));
            for (int k = 0; k < 25; k++) begin
                act = int'($urandom_range(0, 9));
                if (act <= 5)
                    press(fav == 1, fav == 0, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
                else if (act <= 7)
                    press(fav == 0, fav == 1, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
                else if (act == 8)
                    press(1'b1, 1'b1, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
                else
                    step(int'($urandom_range(1, 4)));
            end
            bus.key_l_raw = 1'($urandom_range(0, 1));
            bus.key_r_raw = 1'($urandom_range(0, 1));
            step(int'($urandom_range(0, 2)));
            do_reset(int'($urandom_range(1, 2)));
            step(int'($urandom_range(0, 3)));
            bus.key_l_raw = 1'b0;
            bus.key_r_raw = 1'b0;
            step(2);
        end

        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
